// File: rtl/vo_pkg.sv
// Shared types and helpers for the match-pair stream packer.
//   match_rec_t    : one source/destination match pair (72 bits)
//   rec_kind_e     : record kind stored alongside each FIFO entry
//   fifo_ent_t     : FIFO entry = kind + payload (markers carry their value in dst_depth)
//   packer_state_e : serializer states
//   *_word helpers : build the 32-bit output words
package vo_pkg;

  localparam int unsigned COOR_W  = 10;
  localparam int unsigned DEPTH_W = 16;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned TAG_W   = 4;

  typedef struct packed {
    logic [COOR_W-1:0]  src_x;
    logic [COOR_W-1:0]  src_y;
    logic [DEPTH_W-1:0] src_depth;
    logic [COOR_W-1:0]  dst_x;
    logic [COOR_W-1:0]  dst_y;
    logic [DEPTH_W-1:0] dst_depth;
  } match_rec_t;

  typedef enum logic [1:0] {
    REC_START = 2'd0,
    REC_PAIR  = 2'd1,
    REC_END   = 2'd2
  } rec_kind_e;

  typedef struct packed {
    rec_kind_e  kind;
    match_rec_t rec;
  } fifo_ent_t;

  localparam int unsigned ENT_W = $bits(fifo_ent_t);

  localparam logic [TAG_W-1:0] TAG_START = 4'hD;
  localparam logic [TAG_W-1:0] TAG_W0    = 4'hA;
  localparam logic [TAG_W-1:0] TAG_W1    = 4'hB;
  localparam logic [TAG_W-1:0] TAG_END   = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W0   = 3'd1,
    ST_W1   = 3'd2,
    ST_W2   = 3'd3,
    ST_MARK = 3'd4
  } packer_state_e;

  // Frame marker word: tag, zero pad, 16-bit value.
  function automatic logic [WORD_W-1:0] marker_word(input logic [TAG_W-1:0] tag,
                                                    input logic [CNT_W-1:0] val);
    return {tag, 12'h000, val};
  endfunction

  function automatic logic [WORD_W-1:0] pair_w0(input match_rec_t r);
    return {TAG_W0, 8'h00, r.src_y, r.src_x};
  endfunction

  function automatic logic [WORD_W-1:0] pair_w1(input match_rec_t r);
    return {TAG_W1, 8'h00, r.dst_y, r.dst_x};
  endfunction

  function automatic logic [WORD_W-1:0] pair_w2(input match_rec_t r);
    return {r.dst_depth, r.src_depth};
  endfunction

endpackage

// File: rtl/match_stream_packer_if.sv
// Match-pair input stream and 32-bit valid/ready output stream.
//   slave  : packer side (consumes match pairs, produces words)
//   master : environment side (produces match pairs, consumes words)
interface match_stream_packer_if;
  import vo_pkg::*;

  logic                 i_frame_start;
  logic                 i_frame_end;
  logic                 i_valid;
  logic [COOR_W-1:0]    i_src_coor_x;
  logic [COOR_W-1:0]    i_src_coor_y;
  logic [DEPTH_W-1:0]   i_src_depth;
  logic [COOR_W-1:0]    i_dst_coor_x;
  logic [COOR_W-1:0]    i_dst_coor_y;
  logic [DEPTH_W-1:0]   i_dst_depth;
  logic [WORD_W-1:0]    o_data;
  logic                 o_valid;
  logic                 o_last;
  logic                 i_ready;

  modport slave (
    input  i_frame_start, i_frame_end, i_valid,
    input  i_src_coor_x, i_src_coor_y, i_src_depth,
    input  i_dst_coor_x, i_dst_coor_y, i_dst_depth,
    input  i_ready,
    output o_data, o_valid, o_last
  );

  modport master (
    output i_frame_start, i_frame_end, i_valid,
    output i_src_coor_x, i_src_coor_y, i_src_depth,
    output i_dst_coor_x, i_dst_coor_y, i_dst_depth,
    output i_ready,
    input  o_data, o_valid, o_last
  );

endinterface

// File: rtl/vo_sync_fifo.sv
// Flop-based synchronous FIFO with occupancy count.
//   clk, rst_n     : clock, async active-low reset
//   push, wdata    : write request / data (ignored when full unless popping)
//   pop            : read request (ignored when empty)
//   rdata_c        : head entry (combinational)
//   empty_c        : FIFO empty (combinational)
//   level          : registered occupancy, 0..DEPTH
module vo_sync_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              pop,
  output logic [WIDTH-1:0]  rdata_c,
  output logic              empty_c,
  output logic [ADDR_W:0]   level
);

  localparam int unsigned LVL_W = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              full_c;
  logic              do_push_c;
  logic              do_pop_c;

  assign empty_c   = (level_q == '0);
  assign full_c    = (level_q == LVL_W'(DEPTH));
  assign do_pop_c  = pop && !empty_c;
  // A push at full is fine when the head leaves in the same cycle.
  assign do_push_c = push && (!full_c || do_pop_c);
  assign rdata_c   = mem[rd_ptr_q];
  assign level     = level_q;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally modulo DEPTH (power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      unique case ({do_push_c, do_pop_c})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/match_stream_packer.sv
// Buffers the match-pair stream into a record FIFO and serializes each record
// into 32-bit words on a valid/ready stream.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus            : match-pair input + word output stream (slave side)
//   o_overflow     : sticky, a record or marker was dropped for lack of room
//   o_proto_err    : sticky, i_valid coincided with a frame marker
//   o_drop_cnt     : dropped pair records, saturating
//   o_fifo_level   : FIFO occupancy
module match_stream_packer
  import vo_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  match_stream_packer_if.slave   bus,
  output logic                   o_overflow,
  output logic                   o_proto_err,
  output logic [CNT_W-1:0]       o_drop_cnt,
  output logic [ADDR_W:0]        o_fifo_level
);

  localparam int unsigned LVL_W = ADDR_W + 1;
  // Pairs leave two slots free so frame markers are never starved.
  localparam logic [LVL_W-1:0] PAIR_LIMIT = LVL_W'(DEPTH - 2);
  localparam logic [LVL_W-1:0] MARK_LIMIT = LVL_W'(DEPTH);

  logic              push_c;
  fifo_ent_t         push_ent_c;
  logic              pop_c;
  logic [ENT_W-1:0]  head_bits_c;
  fifo_ent_t         head_c;
  logic              empty_c;
  logic [LVL_W-1:0]  level;

  logic [CNT_W-1:0]  frame_idx_q, frame_idx_d;
  logic [CNT_W-1:0]  pair_cnt_q,  pair_cnt_d;
  logic              pend_end_q,  pend_end_d;
  logic              overflow_q,  overflow_d;
  logic              proto_err_q, proto_err_d;
  logic [CNT_W-1:0]  drop_cnt_q,  drop_cnt_d;
  logic              drop_pair_c;

  packer_state_e     state_q, state_d;
  match_rec_t        cur_q,   cur_d;
  logic [WORD_W-1:0] data_q,  data_d;
  logic              valid_q, valid_d;
  logic              last_q,  last_d;
  logic              hs_c;
  logic              load_c;

  match_rec_t        in_rec_c;
  logic              room_pair_c;
  logic              room_mark_c;
  logic              any_evt_c;

  vo_sync_fifo #(
    .WIDTH  (ENT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push    (push_c),
    .wdata   (push_ent_c),
    .pop     (pop_c),
    .rdata_c (head_bits_c),
    .empty_c (empty_c),
    .level   (level)
  );

  assign head_c = fifo_ent_t'(head_bits_c);

  assign in_rec_c = '{src_x:     bus.i_src_coor_x,
                      src_y:     bus.i_src_coor_y,
                      src_depth: bus.i_src_depth,
                      dst_x:     bus.i_dst_coor_x,
                      dst_y:     bus.i_dst_coor_y,
                      dst_depth: bus.i_dst_depth};

  assign room_pair_c = (level < PAIR_LIMIT);
  assign room_mark_c = (level < MARK_LIMIT);
  assign any_evt_c   = bus.i_frame_start || bus.i_frame_end || bus.i_valid;

  // Accept logic: at most one record written per cycle.
  always_comb begin
    push_c      = 1'b0;
    push_ent_c  = '0;
    pend_end_d  = 1'b0;
    frame_idx_d = frame_idx_q;
    pair_cnt_d  = pair_cnt_q;
    overflow_d  = overflow_q;
    proto_err_d = proto_err_q;
    drop_pair_c = 1'b0;

    if (pend_end_q) begin
      // Deferred END owns the write slot; anything arriving now is lost.
      if (room_mark_c) begin
        push_c                   = 1'b1;
        push_ent_c.kind          = REC_END;
        push_ent_c.rec.dst_depth = pair_cnt_q;
      end else begin
        overflow_d = 1'b1;
      end
      if (any_evt_c) overflow_d = 1'b1;
      if (bus.i_valid && !bus.i_frame_start && !bus.i_frame_end) drop_pair_c = 1'b1;
    end else if (bus.i_frame_start) begin
      if (bus.i_valid) proto_err_d = 1'b1;
      if (room_mark_c) begin
        push_c                   = 1'b1;
        push_ent_c.kind          = REC_START;
        push_ent_c.rec.dst_depth = frame_idx_q;
        frame_idx_d              = frame_idx_q + CNT_W'(1);
        pair_cnt_d               = '0;
      end else begin
        overflow_d = 1'b1;
      end
      pend_end_d = bus.i_frame_end;
    end else if (bus.i_frame_end) begin
      if (bus.i_valid) proto_err_d = 1'b1;
      if (room_mark_c) begin
        push_c                   = 1'b1;
        push_ent_c.kind          = REC_END;
        push_ent_c.rec.dst_depth = pair_cnt_q;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (bus.i_valid) begin
      if (room_pair_c) begin
        push_c          = 1'b1;
        push_ent_c.kind = REC_PAIR;
        push_ent_c.rec  = in_rec_c;
        pair_cnt_d      = pair_cnt_q + CNT_W'(1);
      end else begin
        overflow_d  = 1'b1;
        drop_pair_c = 1'b1;
      end
    end

    drop_cnt_d = drop_cnt_q;
    if (drop_pair_c && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  assign hs_c   = valid_q && bus.i_ready;
  // Fetch a new record when idle or when the final word of a record is taken.
  assign load_c = (state_q == ST_IDLE) ||
                  (((state_q == ST_W2) || (state_q == ST_MARK)) && hs_c);

  // Serializer next-state and output-register values.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    pop_c   = 1'b0;

    unique case (state_q)
      ST_W0: if (hs_c) begin
        data_d  = pair_w1(cur_q);
        state_d = ST_W1;
      end
      ST_W1: if (hs_c) begin
        data_d  = pair_w2(cur_q);
        state_d = ST_W2;
      end
      default: ;
    endcase

    if (load_c) begin
      if (!empty_c) begin
        pop_c   = 1'b1;
        cur_d   = head_c.rec;
        valid_d = 1'b1;
        if (head_c.kind == REC_PAIR) begin
          state_d = ST_W0;
          data_d  = pair_w0(head_c.rec);
          last_d  = 1'b0;
        end else begin
          state_d = ST_MARK;
          data_d  = marker_word((head_c.kind == REC_END) ? TAG_END : TAG_START,
                                head_c.rec.dst_depth);
          last_d  = (head_c.kind == REC_END);
        end
      end else begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      frame_idx_q <= '0;
      pair_cnt_q  <= '0;
      pend_end_q  <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      frame_idx_q <= frame_idx_d;
      pair_cnt_q  <= pair_cnt_d;
      pend_end_q  <= pend_end_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.o_data    = data_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_last    = last_q;
  assign o_overflow    = overflow_q;
  assign o_proto_err   = proto_err_q;
  assign o_drop_cnt    = drop_cnt_q;
  assign o_fifo_level  = level;

endmodule

// File: tb/tb_match_stream_packer.sv
// Self-checking bench for match_stream_packer: transaction-level model
// (record queue + word cursor) compared every cycle, plus literal word checks.
module tb_match_stream_packer;
  import vo_pkg::*;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;

  logic              clk;
  logic              rst_n;
  logic              overflow;
  logic              proto_err;
  logic [15:0]       drop_cnt;
  logic [ADDR_W:0]   fifo_level;

  match_stream_packer_if bus();

  match_stream_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .bus          (bus),
    .o_overflow   (overflow),
    .o_proto_err  (proto_err),
    .o_drop_cnt   (drop_cnt),
    .o_fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [1:0]  last_idx;
    logic        is_end;
  } mrec_t;

  // Model state
  mrec_t       m_q[$];
  mrec_t       m_cur;
  bit          m_valid;
  int          m_idx;
  logic [15:0] m_frame, m_pcnt, m_drop;
  bit          m_pend, m_ovf, m_perr;

  logic [31:0] wlog[$];
  bit          llog[$];
  int          clog[$];
  int          cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mrec_t mk_mark(input logic [3:0] tag, input logic [15:0] v);
    mrec_t r;
    r.w0 = {tag, 12'h000, v};
    r.w1 = '0;
    r.w2 = '0;
    r.last_idx = 2'd0;
    r.is_end = (tag == 4'hE);
    return r;
  endfunction

  function automatic mrec_t mk_pair(input logic [9:0] sx, input logic [9:0] sy, input logic [15:0] sd,
                                    input logic [9:0] dx, input logic [9:0] dy, input logic [15:0] dd);
    mrec_t r;
    r.w0 = {4'hA, 8'h00, sy, sx};
    r.w1 = {4'hB, 8'h00, dy, dx};
    r.w2 = {dd, sd};
    r.last_idx = 2'd2;
    r.is_end = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] m_word();
    if (m_idx == 0) return m_cur.w0;
    if (m_idx == 1) return m_cur.w1;
    return m_cur.w2;
  endfunction

  function automatic logic [31:0] get_w(input int i);
    if (i < wlog.size()) return wlog[i];
    return 32'hBAD0_BAD0;
  endfunction

  // Behavioural model: records queue, one record on the output at a time.
  always @(posedge clk or negedge rst_n) begin : model
    int lvl;
    bit hs, s, e, v;
    if (!rst_n) begin
      m_q.delete();
      m_cur   = '0;
      m_valid = 0;
      m_idx   = 0;
      m_frame = 0;
      m_pcnt  = 0;
      m_drop  = 0;
      m_pend  = 0;
      m_ovf   = 0;
      m_perr  = 0;
    end else begin
      lvl = m_q.size();
      hs  = m_valid && bus.i_ready;
      s   = bus.i_frame_start;
      e   = bus.i_frame_end;
      v   = bus.i_valid;
      // output side
      if (hs && (m_idx < int'(m_cur.last_idx))) begin
        m_idx++;
      end else if (!m_valid || hs) begin
        if (m_q.size() > 0) begin
          m_cur   = m_q.pop_front();
          m_idx   = 0;
          m_valid = 1;
        end else begin
          m_valid = 0;
        end
      end
      // input side, room judged on occupancy before this edge
      if (m_pend) begin
        m_pend = 0;
        if (lvl < DEPTH) m_q.push_back(mk_mark(4'hE, m_pcnt));
        else m_ovf = 1;
        if (s || e || v) m_ovf = 1;
        if (v && !s && !e && m_drop != 16'hFFFF) m_drop++;
      end else if (s) begin
        if (v) m_perr = 1;
        if (lvl < DEPTH) begin
          m_q.push_back(mk_mark(4'hD, m_frame));
          m_frame++;
          m_pcnt = 0;
        end else m_ovf = 1;
        m_pend = e;
      end else if (e) begin
        if (v) m_perr = 1;
        if (lvl < DEPTH) m_q.push_back(mk_mark(4'hE, m_pcnt));
        else m_ovf = 1;
      end else if (v) begin
        if (lvl < DEPTH - 2) begin
          m_q.push_back(mk_pair(bus.i_src_coor_x, bus.i_src_coor_y, bus.i_src_depth,
                                bus.i_dst_coor_x, bus.i_dst_coor_y, bus.i_dst_depth));
          m_pcnt++;
        end else begin
          m_ovf = 1;
          if (m_drop != 16'hFFFF) m_drop++;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("o_valid", 32'(bus.o_valid), 32'(m_valid));
      if (m_valid) begin
        chk("o_data", bus.o_data, m_word());
        chk("o_last", 32'(bus.o_last), 32'(m_cur.is_end));
      end
      chk("o_fifo_level", 32'(fifo_level), 32'(m_q.size()));
      chk("o_overflow", 32'(overflow), 32'(m_ovf));
      chk("o_proto_err", 32'(proto_err), 32'(m_perr));
      chk("o_drop_cnt", 32'(drop_cnt), 32'(m_drop));
    end
  end

  // Accepted-word log.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.o_valid && bus.i_ready) begin
      wlog.push_back(bus.o_data);
      llog.push_back(bus.o_last);
      clog.push_back(cyc);
    end
  end

  task automatic drive(input bit s, input bit e, input bit v,
                       input logic [9:0] sx, input logic [9:0] sy, input logic [15:0] sd,
                       input logic [9:0] dx, input logic [9:0] dy, input logic [15:0] dd);
    bus.i_frame_start = s;
    bus.i_frame_end   = e;
    bus.i_valid       = v;
    bus.i_src_coor_x  = sx;
    bus.i_src_coor_y  = sy;
    bus.i_src_depth   = sd;
    bus.i_dst_coor_x  = dx;
    bus.i_dst_coor_y  = dy;
    bus.i_dst_depth   = dd;
    @(posedge clk);
    #1;
    bus.i_frame_start = 1'b0;
    bus.i_frame_end   = 1'b0;
    bus.i_valid       = 1'b0;
  endtask

  task automatic marks(input bit s, input bit e);
    drive(s, e, 1'b0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while ((m_valid || m_q.size() != 0 || m_pend) && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(n < max_cyc), 32'd1);
  endtask

  logic [31:0] exp1 [8] = '{32'hD000_0000, 32'hA000_500A, 32'hB000_580C, 32'h006E_0064,
                            32'hA000_1805, 32'hB000_2408, 32'h000A_0007, 32'hE000_0002};
  logic [31:0] exp3 [5] = '{32'hD000_0003, 32'hA000_0801, 32'hB000_1404, 32'h0006_0003,
                            32'hE000_0001};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit found;
    int n;
    rst_n = 1'b0;
    bus.i_frame_start = 0; bus.i_frame_end = 0; bus.i_valid = 0;
    bus.i_src_coor_x = 0; bus.i_src_coor_y = 0; bus.i_src_depth = 0;
    bus.i_dst_coor_x = 0; bus.i_dst_coor_y = 0; bus.i_dst_depth = 0;
    bus.i_ready = 1'b1;
    #12;
    chk("rst_o_valid",  32'(bus.o_valid), 32'd0);
    chk("rst_o_data",   bus.o_data, 32'd0);
    chk("rst_o_last",   32'(bus.o_last), 32'd0);
    chk("rst_level",    32'(fifo_level), 32'd0);
    chk("rst_drop",     32'(drop_cnt), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_proto",    32'(proto_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame with two pairs
    wlog.delete(); llog.delete();
    marks(1, 0);
    drive(0, 0, 1, 10'd10, 10'd20, 16'd100, 10'd12, 10'd22, 16'd110);
    drive(0, 0, 1, 10'd5, 10'd6, 16'd7, 10'd8, 10'd9, 16'd10);
    marks(0, 1);
    drain("t1_drain", 100);
    chk("t1_count", 32'(wlog.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("t1_word%0d", i), get_w(i), exp1[i]);
    chk("t1_last_end", 32'((llog.size() == 8) && llog[7]), 32'd1);
    chk("t1_last_pair", 32'((llog.size() == 8) && llog[6]), 32'd0);
    wlog.delete();
    marks(1, 0);
    drain("t1b_drain", 50);
    chk("t1_next_start", get_w(0), 32'hD000_0001);

    // Backpressure burst: 70 pairs with consumer stalled
    bus.i_ready = 1'b0;
    wlog.delete();
    marks(1, 0);
    for (int i = 0; i < 70; i++)
      drive(0, 0, 1, 10'(i), 10'(i + 1), 16'(i * 3), 10'(i + 2), 10'(i + 3), 16'(i * 5));
    marks(0, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("t2_drop_cnt", 32'(drop_cnt), 32'd8);
    chk("t2_overflow", 32'(overflow), 32'd1);
    chk("t2_level", 32'(fifo_level), 32'd63);
    chk("t2_held_valid", 32'(bus.o_valid), 32'd1);
    chk("t2_held_data", bus.o_data, 32'hD000_0002);
    bus.i_ready = 1'b1;
    drain("t2_drain", 400);
    chk("t2_count", 32'(wlog.size()), 32'd188);
    chk("t2_end_word", get_w(187), 32'hE000_003E);

    // Toggling ready during a pair
    wlog.delete(); clog.delete();
    for (int c = 0; c < 30; c++) begin
      bus.i_ready = (c % 2 == 0);
      if (c == 0) drive(1, 0, 0, '0, '0, '0, '0, '0, '0);
      else if (c == 2) drive(0, 0, 1, 10'd1, 10'd2, 16'd3, 10'd4, 10'd5, 16'd6);
      else if (c == 4) drive(0, 1, 0, '0, '0, '0, '0, '0, '0);
      else begin @(posedge clk); #1; end
    end
    bus.i_ready = 1'b1;
    drain("t3_drain", 50);
    chk("t3_count", 32'(wlog.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("t3_word%0d", i), get_w(i), exp3[i]);
    chk("t3_pair_span", 32'((clog.size() >= 4) && (clog[3] - clog[1] >= 4)), 32'd1);

    // Pair coinciding with frame end
    wlog.delete();
    marks(1, 0);
    drive(0, 0, 1, 10'd7, 10'd7, 16'd7, 10'd7, 10'd7, 16'd7);
    drive(0, 1, 1, 10'd9, 10'd9, 16'd9, 10'd9, 10'd9, 16'd9);
    drain("t4_drain", 50);
    chk("t4_proto_err", 32'(proto_err), 32'd1);
    chk("t4_drop_cnt", 32'(drop_cnt), 32'd8);
    chk("t4_count", 32'(wlog.size()), 32'd5);
    chk("t4_end_word", get_w(4), 32'hE000_0001);

    // Start and end in the same cycle
    wlog.delete();
    marks(1, 1);
    drain("t5_drain", 50);
    chk("t5_count", 32'(wlog.size()), 32'd2);
    chk("t5_start", get_w(0), 32'hD000_0005);
    chk("t5_end", get_w(1), 32'hE000_0000);

    // Reset while the second word of a pair is on the output
    marks(1, 0);
    drive(0, 0, 1, 10'd1, 10'd2, 16'd3, 10'd4, 10'd5, 16'd6);
    found = 0;
    n = 0;
    while (!found && n < 20) begin
      @(negedge clk);
      if (bus.o_valid && bus.o_data[31:28] == 4'hB) found = 1;
      n++;
    end
    bus.i_ready = 1'b0;
    chk("t6_reached_w1", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.o_valid), 32'd0);
    chk("t6_level", 32'(fifo_level), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    chk("t6_overflow", 32'(overflow), 32'd0);
    chk("t6_proto", 32'(proto_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    wlog.delete();
    marks(1, 0);
    drain("t6_drain", 50);
    chk("t6_start_idx0", get_w(0), 32'hD000_0000);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_stream_packer.md
Name: match_stream_packer

Overview:
- Downstream stage of the top-level VO chip. Consumes the match-pair stream (frame_start / valid / frame_end pulses with src/dst coordinates and depths) and buffers it in a record FIFO.
- Serializes each record into 32-bit words on a valid/ready stream toward the host/DMA.
- The upstream stream has no backpressure, so this block absorbs bursts, and drops and accounts for records when full.

Parameters:
- DEPTH, 64, number of FIFO record entries (power of 2, ≥4)
- ADDR_W, 6, log2(DEPTH)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_frame_start  in  1  one-cycle frame-start pulse from matcher
- i_frame_end  in  1  one-cycle frame-end pulse from matcher
- i_valid  in  1  match pair valid, one-cycle pulse
- i_src_coor_x / i_src_coor_y  in  10 each  source keypoint coordinates
- i_src_depth  in  16  source depth
- i_dst_coor_x / i_dst_coor_y  in  10 each  destination keypoint coordinates
- i_dst_depth  in  16  destination depth
- o_data  out  32  output word
- o_valid  out  1  o_data valid
- i_ready  in  1  consumer ready
- o_last  out  1  high on the frame-end marker word
- o_overflow  out  1  sticky: a record or marker was dropped
- o_proto_err  out  1  sticky: i_valid coincided with a frame marker
- o_drop_cnt  out  16  dropped pair records, saturating
- o_fifo_level  out  ADDR_W+1  current FIFO occupancy

Behaviour:
- Clock and reset: single clock i_clk; asynchronous active-low reset i_rst_n.
- Reset values: all outputs 0; FIFO empty; frame index 0; pair count 0; FSM IDLE. Reset mid-transfer aborts the word in flight; no partial record is resumed.

Record kinds (2-bit), accepted at most one per cycle:
- START: payload frame_idx.
- PAIR: 72-bit payload.
- END: payload pair_cnt.

Accept rules:
- PAIR accepted only if level < DEPTH-2; otherwise dropped, o_drop_cnt++ (saturates at 0xFFFF), o_overflow set.
- START/END accepted if level < DEPTH (two reserved slots); otherwise dropped, o_overflow set.
- START enqueues the current frame_idx, then frame_idx++ (16-bit wrap) and pair_cnt is cleared.
- END enqueues pair_cnt (accepted pairs only, 16-bit).
- Same-cycle events:
  - i_frame_start and i_frame_end together: START written this cycle, END held one cycle in a pending register and written next cycle.
  - i_valid with either marker: pair dropped (not counted in o_drop_cnt), o_proto_err set, marker written.

Word formats (msb→lsb):
- START: {4'hD, 12'h000, frame_idx[15:0]}
- PAIR w0: {4'hA, 8'h00, src_y, src_x}
- PAIR w1: {4'hB, 8'h00, dst_y, dst_x}
- PAIR w2: {dst_depth, src_depth}
- END: {4'hE, 12'h000, pair_cnt[15:0]}, o_last=1

Serializer FSM:
- States: IDLE, W0, W1, W2, MARK.
- IDLE + FIFO non-empty: pop head; next state W0 (PAIR) or MARK (START/END).
- W0→W1→W2: each transition on o_valid && i_ready.
- W2 or MARK on handshake: pop the next record if available and go directly to W0/MARK (no bubble); else IDLE.
- o_data, o_valid, o_last are registered and held stable while o_valid && !i_ready.

Latency and throughput:
- Record written at cycle t → FIFO head at t+1 → o_valid at t+2 when the serializer is idle.
- Throughput: 3 cycles per pair, 1 per marker, with i_ready held high.

FIFO and level:
- Simultaneous push and pop at full or empty are legal.
- o_fifo_level reflects both in the same cycle.
- Pointers wrap modulo DEPTH.

Decomposition:
- Package vo_pkg:
  - match_rec_t struct (src_x, src_y, src_depth, dst_x, dst_y, dst_depth)
  - rec_kind_e enum {START, PAIR, END}
  - tag constants TAG_START=4'hD, TAG_W0=4'hA, TAG_W1=4'hB, TAG_END=4'hE
  - packer_state_e
- Sub-module vo_sync_fifo: flop-based, parameterized width/depth, push/pop/level.
- Top contains accept logic, counters and the serializer FSM.

Test Plan:
- Frame_start; 2 pairs (src 10,20,d100 / dst 12,22,d110 and src 5,6,d7 / dst 8,9,d10); frame_end; i_ready=1 → words D000_0000, A000_500A, B000_580C, 006E_0064, then pair 2 words, E000_0002 with o_last=1; then frame_idx=1 on next START.
- i_ready=0 during 70 consecutive pairs after START → 62 accepted, 8 dropped, o_drop_cnt=8, o_overflow=1; END still accepted, carries pair_cnt=62 (0x003E).
- i_ready toggling 1010… during a pair → each word held stable until handshake; no duplication or loss; 6+ cycles per pair.
- i_valid and i_frame_end same cycle → o_proto_err=1; END word pair_cnt excludes that pair; o_drop_cnt unchanged.
- i_frame_start and i_frame_end same cycle → START then END (pair_cnt=0) emitted in order.
- Assert i_rst_n low while the FSM is in W1 → o_valid=0 immediately, level=0, counters 0; next frame emits START with frame_idx=0.
